phys_reg_free_list: RTL and testbench

//  Circular free pool of physical register tags. It feeds rename with the tag for each new destination register.
//  It reclaims the old tags that the reorder buffer releases at retire, up to two per cycle.

---
 rtl/phys_reg_free_list_if.sv | 34 +++
 rtl/phys_reg_free_list.sv | 107 ++++++++++
 tb/tb_phys_reg_free_list.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Bus between the physical register free list, rename (allocation) and
// retire (release of old tags).
interface phys_reg_free_list_if #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
);
    localparam int PREG_W = $clog2(NUM_PREG);
    localparam int CAP    = NUM_PREG - NUM_AREG;
    localparam int CNT_W  = $clog2(CAP) + 1;

    logic              alloc_req;
    logic [PREG_W-1:0] free_tag;
    logic              free_avail;
    logic              stall;
    logic [CNT_W-1:0]  free_count;
    logic              rel_en_1;
    logic [PREG_W-1:0] rel_tag_1;
    logic              rel_en_2;
    logic [PREG_W-1:0] rel_tag_2;
    logic              dbl_free_err;
    logic              overflow_err;

    // Rename/retire side: requests tags and returns old ones.
    modport master (
        output alloc_req, rel_en_1, rel_tag_1, rel_en_2, rel_tag_2,
        input  free_tag, free_avail, stall, free_count, dbl_free_err, overflow_err
    );

    // Free list side.
    modport slave (
        input  alloc_req, rel_en_1, rel_tag_1, rel_en_2, rel_tag_2,
        output free_tag, free_avail, stall, free_count, dbl_free_err, overflow_err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular pool of free physical register tags. One tag is handed to rename
// per cycle; up to two old tags come back from retire per cycle. A per-tag
// free bitmap rejects double releases so the pool never holds a tag twice.
module phys_reg_free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    phys_reg_free_list_if.slave     bus
);
    localparam int PREG_W = $clog2(NUM_PREG);
    localparam int CAP    = NUM_PREG - NUM_AREG;
    localparam int PTR_W  = $clog2(CAP);
    localparam int CNT_W  = $clog2(CAP) + 1;
    localparam int ROOM_W = CNT_W + 1;

    logic [PREG_W-1:0]   entry [CAP];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;
    logic [NUM_PREG-1:0] is_free;
    logic                dbl_q, ovf_q;

    logic                pop;
    logic [NUM_PREG-1:0] eff_free;
    logic                q1, q2, dbl1, dbl2, same_tag;
    logic [ROOM_W-1:0]   room;
    logic                acc1, acc2, ovf;
    logic [PTR_W-1:0]    wr2_ptr, tail_next;
    logic [CNT_W-1:0]    count_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CAP - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.free_tag     = entry[head];
    assign bus.free_avail   = (count != '0);
    assign bus.stall        = (count == '0);
    assign bus.free_count   = count;
    assign bus.dbl_free_err = dbl_q;
    assign bus.overflow_err = ovf_q;

    // Qualify the two releases, apply the capacity limit and compute next pointers/count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        eff_free = is_free;
        pop      = bus.alloc_req && (count != '0);
        // The tag handed out this cycle is no longer free, so releasing it is legal.
        if (pop) eff_free[entry[head]] = 1'b0;

        q1       = bus.rel_en_1 && (bus.rel_tag_1 != '0) && !eff_free[bus.rel_tag_1];
        dbl1     = bus.rel_en_1 && (bus.rel_tag_1 != '0) &&  eff_free[bus.rel_tag_1];
        same_tag = q1 && (bus.rel_tag_1 == bus.rel_tag_2);
        q2       = bus.rel_en_2 && (bus.rel_tag_2 != '0) && !eff_free[bus.rel_tag_2] && !same_tag;
        dbl2     = bus.rel_en_2 && (bus.rel_tag_2 != '0) && (eff_free[bus.rel_tag_2] || same_tag);

        // Free slots after this cycle's pop; slot 2 is the first to be dropped.
        room = ROOM_W'(CAP) - ROOM_W'(count) + ROOM_W'(pop);
        acc1 = q1 && (room != '0);
        acc2 = q2 && (room > ROOM_W'(acc1));
        ovf  = (q1 && !acc1) || (q2 && !acc2);

        wr2_ptr    = acc1 ? ptr_inc(tail) : tail;
        tail_next  = acc2 ? ptr_inc(wr2_ptr) : wr2_ptr;
        count_next = count - CNT_W'(pop) + CNT_W'(acc1) + CNT_W'(acc2);
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(CAP);
            dbl_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (pop) head <= ptr_inc(head);
            tail  <= tail_next;
            count <= count_next;
            if (dbl1 || dbl2) dbl_q <= 1'b1;
            if (ovf)          ovf_q <= 1'b1;
        end
    end

    // Tag storage: accepted releases are written at the tail in slot order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: this array is reset on purpose; the pool must start holding p(NUM_AREG)..p(NUM_PREG-1).
            for (int i = 0; i < CAP; i++) entry[i] <= PREG_W'(NUM_AREG + i);
        end else begin
            if (acc1) entry[tail]    <= bus.rel_tag_1;
            if (acc2) entry[wr2_ptr] <= bus.rel_tag_2;
        end
    end

    // Free bitmap: cleared on allocation, set on accepted release (release wins).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < NUM_PREG; t++) is_free[t] <= (t >= NUM_AREG);
        end else begin
            if (pop)  is_free[entry[head]]   <= 1'b0;
            if (acc1) is_free[bus.rel_tag_1] <= 1'b1;
            if (acc2) is_free[bus.rel_tag_2] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed and random checks of the physical register free list against a
// queue-based model of the pool.
module tb_phys_reg_free_list;
    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam int CAP      = NUM_PREG - NUM_AREG;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    phys_reg_free_list_if #(.NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG)) bus ();

    phys_reg_free_list #(.NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pool order as a queue, free set as a bit per tag.
    int pool[$];
    bit mfree[NUM_PREG];
    bit mdbl, movf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pool.delete();
        for (int i = 0; i < CAP; i++) pool.push_back(NUM_AREG + i);
        for (int t = 0; t < NUM_PREG; t++) mfree[t] = (t >= NUM_AREG);
        mdbl = 1'b0;
        movf = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit e1, input int t1, input bit e2, input int t2);
        bit pop, ok1, ok2;
        int popped, room;
        popped = -1;
        ok1 = 1'b0;
        ok2 = 1'b0;
        pop = a && (pool.size() != 0);
        if (pop) popped = pool[0];
        if (e1 && t1 != 0) begin
            if (mfree[t1] && t1 != popped) mdbl = 1'b1;
            else ok1 = 1'b1;
        end
        if (e2 && t2 != 0) begin
            if ((mfree[t2] && t2 != popped) || (ok1 && t1 == t2)) mdbl = 1'b1;
            else ok2 = 1'b1;
        end
        room = CAP - pool.size() + (pop ? 1 : 0);
        if (pop) begin
            void'(pool.pop_front());
            mfree[popped] = 1'b0;
        end
        if (ok1) begin
            if (room > 0) begin pool.push_back(t1); mfree[t1] = 1'b1; room--; end
            else movf = 1'b1;
        end
        if (ok2) begin
            if (room > 0) begin pool.push_back(t2); mfree[t2] = 1'b1; room--; end
            else movf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_avail"}, 32'(bus.free_avail), 32'(pool.size() != 0));
        check({tag, "_stall"}, 32'(bus.stall), 32'(pool.size() == 0));
        check({tag, "_count"}, 32'(bus.free_count), 32'(pool.size()));
        if (pool.size() != 0) check({tag, "_tag"}, 32'(bus.free_tag), 32'(pool[0]));
        check({tag, "_dbl"}, 32'(bus.dbl_free_err), 32'(mdbl));
        check({tag, "_ovf"}, 32'(bus.overflow_err), 32'(movf));
    endtask

    // One clock of stimulus: drive at negedge, verify no same-cycle bypass, check after the edge.
    task automatic step(input string tag, input bit a, input bit e1, input int t1,
                        input bit e2, input int t2);
        @(negedge clk);
        bus.alloc_req = a;
        bus.rel_en_1  = e1;
        bus.rel_tag_1 = 6'(t1);
        bus.rel_en_2  = e2;
        bus.rel_tag_2 = 6'(t2);
        #1;
        check({tag, "_nobypass"}, 32'(bus.free_avail), 32'(pool.size() != 0));
        model_step(a, e1, t1, e2, t2);
        @(posedge clk);
        #1;
        check_all(tag);
        bus.alloc_req = 1'b0;
        bus.rel_en_1  = 1'b0;
        bus.rel_en_2  = 1'b0;
    endtask

    initial begin
        int exp_seq[7];
        int cnt_before;
        int t;

        bus.alloc_req = 1'b0;
        bus.rel_en_1  = 1'b0;
        bus.rel_tag_1 = '0;
        bus.rel_en_2  = 1'b0;
        bus.rel_tag_2 = '0;
        model_reset();

        // 1. Reset state.
        #12 rstn = 1'b1;
        #1;
        check_all("reset");
        check("reset_tag32", 32'(bus.free_tag), 32'd32);
        check("reset_count32", 32'(bus.free_count), 32'd32);

        // 2. Drain the whole pool in order, then alloc while empty.
        for (int i = 0; i < CAP; i++) begin
            check("drain_seq", 32'(bus.free_tag), 32'(32 + i));
            step("drain", 1'b1, 1'b0, 0, 1'b0, 0);
        end
        check("empty_stall", 32'(bus.stall), 32'd1);
        check("empty_count", 32'(bus.free_count), 32'd0);
        step("empty_alloc", 1'b1, 1'b0, 0, 1'b0, 0);

        // 3. Dual release into an empty pool.
        step("rel_empty", 1'b0, 1'b1, 40, 1'b1, 33);
        check("rel_empty_tag40", 32'(bus.free_tag), 32'd40);
        check("rel_empty_cnt2", 32'(bus.free_count), 32'd2);
        step("pop40", 1'b1, 1'b0, 0, 1'b0, 0);
        check("pop40_tag33", 32'(bus.free_tag), 32'd33);

        // 4. Pop and two releases in one cycle at count=5.
        step("fill_a", 1'b0, 1'b1, 10, 1'b1, 11);
        step("fill_b", 1'b0, 1'b1, 12, 1'b1, 13);
        check("cnt5", 32'(bus.free_count), 32'd5);
        step("pop_rel2", 1'b1, 1'b1, 50, 1'b1, 51);
        check("cnt6", 32'(bus.free_count), 32'd6);
        step("rel_popped33", 1'b0, 1'b1, 33, 1'b0, 0);
        check("rel_popped33_nodbl", 32'(bus.dbl_free_err), 32'd0);
        exp_seq = '{10, 11, 12, 13, 50, 51, 33};
        for (int i = 0; i < 7; i++) begin
            check("order", 32'(bus.free_tag), 32'(exp_seq[i]));
            step("order_pop", 1'b1, 1'b0, 0, 1'b0, 0);
        end

        // 5. Double releases and tag 0.
        step("rel45", 1'b0, 1'b1, 45, 1'b0, 0);
        step("dbl45", 1'b0, 1'b0, 0, 1'b1, 45);
        check("dbl45_flag", 32'(bus.dbl_free_err), 32'd1);
        step("dual7", 1'b0, 1'b1, 7, 1'b1, 7);
        check("dual7_cnt", 32'(bus.free_count), 32'd2);
        step("idle", 1'b0, 1'b0, 0, 1'b0, 0);
        check("dbl_sticky", 32'(bus.dbl_free_err), 32'd1);
        cnt_before = pool.size();
        step("tag0", 1'b0, 1'b1, 0, 1'b1, 0);
        check("tag0_cnt", 32'(bus.free_count), 32'(cnt_before));

        // 6. Overflow on a full pool, then reset mid-sequence.
        t = 8;
        while (pool.size() < CAP && t < NUM_PREG) begin
            if (!mfree[t]) step("fill", 1'b0, 1'b1, t, 1'b0, 0);
            t++;
        end
        check("full_cnt", 32'(bus.free_count), 32'd32);
        step("ovf56", 1'b0, 1'b1, 5, 1'b1, 6);
        check("ovf_flag", 32'(bus.overflow_err), 32'd1);
        check("ovf_cnt", 32'(bus.free_count), 32'd32);
        step("pop_before_rst", 1'b1, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        bus.alloc_req = 1'b1;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        bus.alloc_req = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_all("rst_released");
        check("rst_tag32", 32'(bus.free_tag), 32'd32);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NUM_PREG - 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NUM_PREG - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
